// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the digit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DIGIT = 4;

endpackage

// File: rtl/digit_subtractor.sv
// Combinational DIGIT-bit ripple subtractor built from full-subtractor cells.
module digit_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned DIGIT = DEFAULT_DIGIT
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             bin_i,
    output logic [DIGIT-1:0] diff_o,
    output logic             bout_o
);

    logic [DIGIT:0] br;

    always_comb begin
        br     = '0;
        diff_o = '0;
        br[0]  = bin_i;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            diff_o[i] = a_i[i] ^ b_i[i] ^ br[i];
            br[i+1]   = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & br[i]);
        end
    end

    assign bout_o = br[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: a - b - bin, DIGIT bits per cycle, valid/ready on both sides.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DIGIT = DEFAULT_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_subtractor: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, diff_q, diff_d;
    logic             a_msb_q, b_msb_q, borrow_q;
    logic             bout_q, zero_q, ovf_q, in_ready_q, out_valid_q;
    logic [DIGIT-1:0] dig_diff;
    logic             dig_bout;

    digit_subtractor #(.DIGIT(DIGIT)) u_digit (
        .a_i    (a_q[DIGIT-1:0]),
        .b_i    (b_q[DIGIT-1:0]),
        .bin_i  (borrow_q),
        .diff_o (dig_diff),
        .bout_o (dig_bout)
    );

    // Operands shift right and results shift in from the top, so after N
    // cycles diff_q holds the full result with digit 0 at the LSB end.
    generate
        if (N == 1) begin : g_single
            assign diff_d = dig_diff;
        end else begin : g_multi
            assign diff_d = {dig_diff, diff_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            borrow_q    <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        a_msb_q    <= a[WIDTH-1];
                        b_msb_q    <= b[WIDTH-1];
                        borrow_q   <= bin;
                        cnt_q      <= '0;
                        diff_q     <= '0;
                        bout_q     <= 1'b0;
                        zero_q     <= 1'b0;
                        ovf_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    a_q      <= a_q >> DIGIT;
                    b_q      <= b_q >> DIGIT;
                    borrow_q <= dig_bout;
                    diff_q   <= diff_d;
                    if (cnt_q == LAST) begin
                        bout_q      <= dig_bout;
                        zero_q      <= (diff_d == '0);
                        ovf_q       <= (a_msb_q != b_msb_q) && (diff_d[WIDTH-1] != a_msb_q);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: four WIDTH=8 instances (DIGIT 4, 1, 2, 8) driven in lockstep.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] op_a = '0;
    logic [7:0] op_b = '0;
    logic       op_bin = 1'b0;

    logic [3:0]      irr, ovv, bov, zrv, ofv;
    logic [3:0][7:0] dfv;

    int checks = 0;
    int passed = 0;
    int lat[4];
    int exp_lat[4] = '{2, 8, 4, 1};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned DG = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 8;
        serial_subtractor #(.WIDTH(8), .DIGIT(DG)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (irr[g]),
            .a         (op_a),
            .b         (op_b),
            .bin       (op_bin),
            .out_valid (ovv[g]),
            .out_ready (out_ready),
            .diff      (dfv[g]),
            .bout      (bov[g]),
            .zero      (zrv[g]),
            .ovf       (ofv[g])
        );
    end

    // Reference: widen to 9 bits and subtract; bit 8 is the unsigned borrow.
    function automatic logic [8:0] ref_sub(input logic [7:0] x, input logic [7:0] y, input logic c);
        return {1'b0, x} - {1'b0, y} - {8'd0, c};
    endfunction

    function automatic logic ref_ovf(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] r;
        r = ref_sub(x, y, c);
        return (x[7] != y[7]) && (r[7] != x[7]);
    endfunction

    // Launch one operation on all instances; in_valid is left high with junk
    // operands while they compute, which must be ignored.
    task automatic do_op(input logic [7:0] xa, input logic [7:0] xb, input logic xc, output bit to);
        int c;
        to = 1'b0;
        c = 0;
        while (irr != 4'hF && c < 50) begin
            @(posedge clk); #1; c++;
        end
        if (irr != 4'hF) begin
            to = 1'b1;
            return;
        end
        @(negedge clk);
        op_a = xa; op_b = xb; op_bin = xc; in_valid = 1'b1;
        @(posedge clk); #1;
        op_a = 8'($urandom); op_b = 8'($urandom); op_bin = 1'($urandom);
        for (int i = 0; i < 4; i++) lat[i] = 0;
        c = 0;
        while (ovv != 4'hF && c < 40) begin
            @(posedge clk); #1; c++;
            for (int i = 0; i < 4; i++) if (ovv[i] && lat[i] == 0) lat[i] = c;
        end
        in_valid = 1'b0;
        if (ovv != 4'hF) to = 1'b1;
    endtask

    task automatic release_all();
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ovv !== 4'h0) $display("FAIL reset_out_valid got %b want 0000", ovv); else passed++;
        checks++; if (irr !== 4'hF) $display("FAIL reset_in_ready got %b want 1111", irr); else passed++;
        checks++; if (dfv !== '0) $display("FAIL reset_diff got %h want 0", dfv); else passed++;
        checks++; if ({bov, zrv, ofv} !== 12'h0) $display("FAIL reset_flags got %h want 000", {bov, zrv, ofv}); else passed++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [7:0] va[5] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h5A};
        logic [7:0] vb[5] = '{8'h03, 8'h05, 8'h00, 8'h01, 8'h5A};
        logic       vc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] ed[5] = '{8'h02, 8'hFE, 8'hFF, 8'h7F, 8'h00};
        logic       eb[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       ez[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       eo[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bit to;
        for (int v = 0; v < 5; v++) begin
            do_op(va[v], vb[v], vc[v], to);
            checks++; if (to) $display("FAIL dir%0d_timeout out_valid %b want 1111", v, ovv); else passed++;
            for (int i = 0; i < 4; i++) begin
                checks++; if (lat[i] != exp_lat[i]) $display("FAIL dir%0d_latency dut%0d got %0d want %0d", v, i, lat[i], exp_lat[i]); else passed++;
                checks++; if (dfv[i] !== ed[v]) $display("FAIL dir%0d_diff dut%0d got %h want %h", v, i, dfv[i], ed[v]); else passed++;
                checks++; if (bov[i] !== eb[v]) $display("FAIL dir%0d_bout dut%0d got %b want %b", v, i, bov[i], eb[v]); else passed++;
                checks++; if (zrv[i] !== ez[v]) $display("FAIL dir%0d_zero dut%0d got %b want %b", v, i, zrv[i], ez[v]); else passed++;
                checks++; if (ofv[i] !== eo[v]) $display("FAIL dir%0d_ovf dut%0d got %b want %b", v, i, ofv[i], eo[v]); else passed++;
            end
            release_all();
            checks++; if (irr !== 4'hF || ovv !== 4'h0) $display("FAIL dir%0d_release in_ready %b out_valid %b want 1111 0000", v, irr, ovv); else passed++;
        end
    endtask

    task automatic test_stall();
        logic [7:0] xa, xb;
        logic       xc;
        logic [8:0] r;
        bit to;
        xa = 8'h3C; xb = 8'hC3; xc = 1'b1;
        r = ref_sub(xa, xb, xc);
        do_op(xa, xb, xc, to);
        checks++; if (to) $display("FAIL stall_timeout out_valid %b want 1111", ovv); else passed++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1; op_a = 8'($urandom); op_b = 8'($urandom); op_bin = 1'($urandom);
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (dfv[i] !== r[7:0] || bov[i] !== r[8] || zrv[i] !== (r[7:0] == 8'h00) || ofv[i] !== ref_ovf(xa, xb, xc))
                    $display("FAIL stall%0d_hold dut%0d got %h/%b/%b/%b want %h/%b/%b/%b", k, i,
                             dfv[i], bov[i], zrv[i], ofv[i], r[7:0], r[8], r[7:0] == 8'h00, ref_ovf(xa, xb, xc));
                else passed++;
            end
            checks++; if (ovv !== 4'hF || irr !== 4'h0) $display("FAIL stall%0d_hs out_valid %b in_ready %b want 1111 0000", k, ovv, irr); else passed++;
        end
        release_all();
        checks++; if (irr !== 4'hF || ovv !== 4'h0) $display("FAIL stall_release in_ready %b out_valid %b want 1111 0000", irr, ovv); else passed++;
    endtask

    task automatic test_reset_mid_calc();
        logic [8:0] r;
        bit to;
        bit seen;
        @(negedge clk);
        op_a = 8'h9E; op_b = 8'h21; op_bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (ovv !== 4'h0 || irr !== 4'hF) $display("FAIL rstcalc_async out_valid %b in_ready %b want 0000 1111", ovv, irr); else passed++;
        checks++; if (dfv !== '0 || {bov, zrv, ofv} !== 12'h0) $display("FAIL rstcalc_outputs diff %h flags %h want 0 000", dfv, {bov, zrv, ofv}); else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ovv !== 4'h0) seen = 1'b1;
        end
        checks++; if (seen) $display("FAIL rstcalc_no_valid got out_valid after reset want none"); else passed++;
        r = ref_sub(8'h10, 8'h20, 1'b1);
        do_op(8'h10, 8'h20, 1'b1, to);
        checks++; if (to) $display("FAIL rstcalc_next_timeout out_valid %b want 1111", ovv); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dfv[i] !== r[7:0] || bov[i] !== r[8])
                $display("FAIL rstcalc_next dut%0d got %h/%b want %h/%b", i, dfv[i], bov[i], r[7:0], r[8]);
            else passed++;
        end
        release_all();
    endtask

    task automatic test_random();
        logic [7:0] xa, xb;
        logic       xc;
        logic [8:0] r;
        logic       eo;
        bit to;
        for (int n = 0; n < 40; n++) begin
            xa = 8'($urandom); xb = 8'($urandom); xc = 1'($urandom);
            if (n == 0) begin xa = 8'hFF; xb = 8'hFF; xc = 1'b1; end
            if (n == 1) begin xa = 8'h7F; xb = 8'h80; xc = 1'b0; end
            r = ref_sub(xa, xb, xc);
            eo = ref_ovf(xa, xb, xc);
            do_op(xa, xb, xc, to);
            checks++; if (to) $display("FAIL rnd%0d_timeout out_valid %b want 1111", n, ovv); else passed++;
            for (int i = 0; i < 4; i++) begin
                checks++; if (lat[i] != exp_lat[i]) $display("FAIL rnd%0d_latency dut%0d got %0d want %0d", n, i, lat[i], exp_lat[i]); else passed++;
                checks++; if (dfv[i] !== r[7:0]) $display("FAIL rnd%0d_diff dut%0d a=%h b=%h bin=%b got %h want %h", n, i, xa, xb, xc, dfv[i], r[7:0]); else passed++;
                checks++; if (bov[i] !== r[8]) $display("FAIL rnd%0d_bout dut%0d got %b want %b", n, i, bov[i], r[8]); else passed++;
                checks++; if (zrv[i] !== (r[7:0] == 8'h00)) $display("FAIL rnd%0d_zero dut%0d got %b want %b", n, i, zrv[i], r[7:0] == 8'h00); else passed++;
                checks++; if (ofv[i] !== eo) $display("FAIL rnd%0d_ovf dut%0d got %b want %b", n, i, ofv[i], eo); else passed++;
            end
            release_all();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid_calc();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
